// File: rtl/quad_decoder.sv
// quad_decoder: quadrature rotary-encoder reader.
// Two-flop synchronizer and per-channel debounce on the A/B pins, followed
// by a Gray-code decoder that drives a 4-bit wrapping position, a direction
// flag, and single-cycle step / err pulses. All outputs are registered.
module quad_decoder #(
  parameter int unsigned DEBOUNCE = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enc_a,
  input  logic       enc_b,
  output logic [3:0] pos,
  output logic       dir,
  output logic       step,
  output logic       err
);

  // Terminal count for the debounce counters (a change is accepted when the
  // counter already holds DEBOUNCE-1 and the pin still differs).
  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE - 1);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  init_cnt;
  logic        init_done;

  logic        s1_a;
  logic        s2_a;
  logic        s1_b;
  logic        s2_b;

  logic        stable_a;
  logic        stable_b;
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;

  logic [1:0]  cur_ab;
  logic [1:0]  prev_ab;
  logic [1:0]  delta;
  logic        move_fwd;
  logic        move_rev;
  logic        move_bad;

  // Map a Gray code {a,b} to its position in the forward cycle 00,01,11,10.
  function automatic logic [1:0] gray_ord(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Last INIT cycle: pins are sampled into stable/prev without counting.
  assign init_done = (state == INIT) && (init_cnt == 2'd2);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic: INIT runs for three cycles, then RUN until reset.
  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (init_cnt == 2'd2) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // INIT cycle counter; holds at 2 once INIT has completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt <= '0;
    end else if ((state == INIT) && (init_cnt != 2'd2)) begin
      init_cnt <= init_cnt + 2'd1;
    end
  end

  // Two-flop synchronizers for the asynchronous encoder pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_a <= 1'b0;
      s2_a <= 1'b0;
      s1_b <= 1'b0;
      s2_b <= 1'b0;
    end else begin
      s1_a <= enc_a;
      s2_a <= s1_a;
      s1_b <= enc_b;
      s2_b <= s1_b;
    end
  end

  // Channel A debounce: accept a new level only after DEBOUNCE differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_a <= 1'b0;
      cnt_a    <= '0;
    end else if (init_done) begin
      stable_a <= s2_a;
      cnt_a    <= '0;
    end else if (state == RUN) begin
      if (s2_a == stable_a) begin
        cnt_a <= '0;
      end else if (cnt_a == DB_LAST) begin
        stable_a <= s2_a;
        cnt_a    <= '0;
      end else begin
        cnt_a <= cnt_a + 16'd1;
      end
    end
  end

  // Channel B debounce: identical filter to channel A.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_b <= 1'b0;
      cnt_b    <= '0;
    end else if (init_done) begin
      stable_b <= s2_b;
      cnt_b    <= '0;
    end else if (state == RUN) begin
      if (s2_b == stable_b) begin
        cnt_b <= '0;
      end else if (cnt_b == DB_LAST) begin
        stable_b <= s2_b;
        cnt_b    <= '0;
      end else begin
        cnt_b <= cnt_b + 16'd1;
      end
    end
  end

  // Classify the move between the previous and current debounced pair.
  // A distance of 1 in the Gray cycle is forward, 3 is reverse, 2 is illegal.
  always_comb begin
    cur_ab   = {stable_a, stable_b};
    delta    = gray_ord(cur_ab) - gray_ord(prev_ab);
    move_fwd = 1'b0;
    move_rev = 1'b0;
    move_bad = 1'b0;
    if (state == RUN) begin
      move_fwd = (delta == 2'd1);
      move_rev = (delta == 2'd3);
      move_bad = (delta == 2'd2);
    end
  end

  // Registered decoder outputs; prev_ab tracks stable_ab even on illegal moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab <= '0;
      pos     <= '0;
      dir     <= 1'b0;
      step    <= 1'b0;
      err     <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (init_done) begin
        // prev_ab is seeded alongside stable so the first RUN cycle sees no move.
        prev_ab <= {s2_a, s2_b};
      end else if (state == RUN) begin
        prev_ab <= cur_ab;
        if (move_fwd) begin
          pos  <= pos + 4'd1;
          dir  <= 1'b1;
          step <= 1'b1;
        end else if (move_rev) begin
          pos  <= pos - 4'd1;
          dir  <= 1'b0;
          step <= 1'b1;
        end else if (move_bad) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature rotary-encoder reader for the iCEstick demo board. It samples two asynchronous encoder pins (A/B), synchronizes and debounces each pin, and decodes the Gray sequence into a 4-bit wrapping position, a direction flag, and single-cycle step and error pulses. It is the input-side counterpart to the free-running LED rotation counter: the position output is sized to drive the same four LEDs (D1..D4), and the direction output is sized to drive D5.

## Interface
- `DEBOUNCE`, default 12000: consecutive cycles a pin must differ from its stable value before the change is accepted (1 ms at 12 MHz); legal range 1..65535.
- `clk` in 1: 12 MHz board clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `enc_a` in 1: encoder channel A, asynchronous.
- `enc_b` in 1: encoder channel B, asynchronous.
- `pos` out 4: position count, wraps modulo 16.
- `dir` out 1: direction of the last valid move; 1 = forward, 0 = reverse.
- `step` out 1: one-cycle pulse on every valid move.
- `err` out 1: one-cycle pulse on every illegal transition.

## Operation
- Synchronizer: two flops per pin (`s1`, `s2`). Reset value is 0.
- States are INIT and RUN.
  - Reset forces INIT, and a 2-bit init counter is cleared.
  - INIT lasts 3 cycles. On the 3rd cycle, `stable_ab` loads `{s2_a, s2_b}` with no count, and the state moves to RUN.
  - This prevents a spurious step when the pins idle high.
- Debounce runs per channel, in RUN only. Each channel has a 16-bit counter.
  - If `s2 == stable`, the counter is set to 0.
  - Otherwise the counter increments.
  - When `s2 != stable` and the counter equals DEBOUNCE-1, `stable` takes `s2` and the counter is set to 0.
  - A glitch shorter than DEBOUNCE cycles never reaches `stable`.
- Decode compares the previous `stable_ab` (`prev_ab`, a registered copy) against the current `stable_ab`, every cycle in RUN.
  - Forward sequence: 00→01→11→10→00. Each such move gives `pos+1`, `dir=1`, `step=1`.
  - Reverse sequence: 00→10→11→01→00. Each such move gives `pos-1`, `dir=0`, `step=1`.
  - No change: outputs hold and the pulses are 0.
  - Both bits change in the same cycle (illegal): `pos` and `dir` unchanged, `step=0`, `err=1`. `prev_ab` still takes the new value, so decoding resynchronizes.
- Arithmetic is 4-bit modulo. 15+1 = 0 and 0-1 = 15, with no saturation and no flag.
- `step` and `err` are never high in the same cycle.

## Timing
- Reset values: `pos=0`, `dir=0`, `step=0`, `err=0`. `stable_ab`, `prev_ab`, debounce counters and synchronizers are all 0.
- Reset asserted mid-debounce or mid-sequence discards all progress. INIT repeats, and no pulse is produced during INIT.
- Latency for a clean pin change, taking edge k as the edge where `s1` captures the new level:
  - `s2` updates at edge k+1.
  - `stable` updates at edge k+1+DEBOUNCE.
  - `pos`/`dir`/`step` update at edge k+2+DEBOUNCE.
- `step`/`err` are high for exactly one cycle per accepted transition.
- Simultaneous acceptance of A and B in one cycle is an illegal transition → `err`.
- Maximum tracked rate is one accepted transition per DEBOUNCE+1 cycles per channel. Faster edges are filtered, not queued.
- All outputs are registered. There are no combinational paths from the inputs to the outputs.

## Test plan
All scenarios use DEBOUNCE=4.
- **Reset with pins idle high:** hold `rst` 2 cycles with A=B=1, release and wait 20 cycles → `pos=0`, `step`/`err` never asserted.
- **Forward walk:** from AB=00, drive 01,11,10,00 repeated 5 times (20 moves), each level held 10 cycles → 20 `step` pulses, `dir=1`, `pos` goes 0→15→0→4 (wraps once), with no `err`.
- **Reverse walk and latency:** from `pos=0`, drive AB 00→10 → `pos=15`, `dir=0`. The `step` pulse arrives exactly DEBOUNCE+2 edges after the `s1` capture edge.
- **Glitch rejection:** with A stable at 0, pulse A high for 3 cycles, then 1 cycle → no `step`, `pos` unchanged. A 5-cycle hold is accepted.
- **Illegal transition:** hold AB=00, then switch both pins to 11 on the same cycle → one `err` pulse, no `step`, `pos` unchanged. A following 11→10 gives `pos+1`.
- **Reset mid-operation:** assert `rst` while A's debounce counter is at 2 → after release, `pos=0` and no `step`. A pin level already at its new value is absorbed in INIT without counting.
